hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core. It works alongside the operand-bypass logic and covers the hazards that bypassing cannot resolve.
- Detects load-use hazards and ID-stage branch/jr operand hazards. Generates PC/IF-ID hold, ID/EX bubble and IF-ID flush controls.
- Runs the halt drain sequence: after a halt instruction, the pipeline empties before the core reports halted.

Parameters:
- NB_REG_ADDR, 5, register address width
- DRAIN_CYCLES, 4, cycles needed to empty ID..WB after halt is accepted
- NB_CNT, 32, width of cycle/stall counters

Ports:
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  pipeline step enable; state and counters advance only when 1
- i_rs  in  NB_REG_ADDR  rs of instruction in ID
- i_rt  in  NB_REG_ADDR  rt of instruction in ID
- i_uses_rt  in  1  ID instruction reads rt (R-type, store, beq/bne)
- i_branch  in  1  ID instruction is beq/bne
- i_jump_rs  in  1  ID instruction is jr/jalr
- i_taken  in  1  branch/jump in ID resolved taken
- i_halt  in  1  ID instruction is halt
- i_rd_ex  in  NB_REG_ADDR  destination in EX
- i_we_ex  in  1  EX writes register file
- i_memread_ex  in  1  EX instruction is a load
- i_rd_mem  in  NB_REG_ADDR  destination in MEM
- i_we_mem  in  1  MEM writes register file
- i_memread_mem  in  1  MEM instruction is a load
- o_stall  out  1  hold PC and IF/ID register
- o_bubble  out  1  load NOP into ID/EX
- o_flush  out  1  clear IF/ID (squash fetched instruction)
- o_halted  out  1  pipeline drained after halt
- o_stall_cnt  out  NB_CNT  stall cycles counted (feature-gated)

Behaviour:
- State register: RUN, DRAIN, HALTED. Reset to RUN; drain counter 0; o_stall_cnt 0.
- While i_reset=1, o_stall, o_bubble, o_flush and o_halted are forced 0.
- Match rules. Register 0 never matches.
  - hit_ex_a = (i_rs==i_rd_ex) & i_we_ex & (i_rd_ex!=0)
  - hit_ex_b = i_uses_rt & (i_rt==i_rd_ex) & i_we_ex & (i_rd_ex!=0)
  - hit_mem_a and hit_mem_b are defined the same way against i_rd_mem/i_we_mem.
- Hazard conditions, combinational, same cycle:
  - load_use = i_memread_ex & (hit_ex_a | hit_ex_b)
  - br_hz = i_branch & (hit_ex_a | hit_ex_b | (i_memread_mem & (hit_mem_a | hit_mem_b)))
  - jr_hz = i_jump_rs & (hit_ex_a | (i_memread_mem & hit_mem_a))
  - hazard = load_use | br_hz | jr_hz
- Load in EX feeding a branch gives 2 consecutive stall cycles by re-evaluation: the first cycle matches on EX, the second on MEM-load. No extra counter is used.
- RUN state:
  - hazard=1: o_stall=1, o_bubble=1, o_flush=0. Taken resolution and halt are ignored because the ID instruction is re-presented.
  - hazard=0 & i_taken=1: o_flush=1 for that cycle.
  - hazard=0 & i_halt=1: o_stall=1, o_bubble=1. Next state DRAIN, drain counter loads DRAIN_CYCLES-1.
  - i_halt has priority over i_taken in the same cycle.
- DRAIN state:
  - o_stall=1, o_bubble=1, o_flush=1.
  - Counter decrements each i_valid cycle. At 0 the next state is HALTED.
- HALTED state:
  - o_stall=1, o_bubble=1, o_halted=1. The state is left only by i_reset.
- i_valid=0: state, drain counter and o_stall_cnt hold. Combinational outputs are still driven from current inputs.
- Reset mid-DRAIN or in HALTED returns to RUN on the next edge; o_halted drops that edge.
- Latency: hazard outputs are combinational (0 cycles). o_halted asserts DRAIN_CYCLES+1 valid cycles after the halt is accepted.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- Defined:
  - o_stall_cnt increments on every i_valid cycle with o_stall=1 in RUN (hazard stalls only).
  - It saturates at all-ones and resets to 0.
- Undefined: o_stall_cnt is tied to 0 and no counter flops are inferred.

Test Plan:
- Load-use: EX lw rd=8, ID add rs=8 → o_stall=1 and o_bubble=1 for exactly 1 cycle, then 0; stall_cnt=1.
- Load then beq: EX lw rd=3, ID beq rs=3 → stall 2 consecutive cycles (EX match, then MEM-load match); stall_cnt=2.
- Register zero: EX lw rd=0, ID add rs=0 → no stall.
- Taken branch with no hazard: ID beq, i_taken=1 → o_flush=1 for 1 cycle.
- Taken branch while hazard: o_flush stays 0 until the hazard clears.
- Halt with DRAIN_CYCLES=4: i_halt=1 in RUN → DRAIN 4 cycles, then o_halted=1 and held. Toggling i_valid=0 mid-drain extends the drain by the same number of cycles.
- Reset in HALTED: i_reset=1 for 1 cycle → next cycle o_halted=0, state RUN, all outputs 0, stall_cnt=0.

Source files
------------

// File: rtl/hazard_control_unit.sv
// =============================================================================
// Module   : hazard_control_unit
// Brief    : Load-use / ID-branch hazard stalls, taken flush, halt drain.
//            Optional stall counter enabled by macro HAZARD_STALL_CNT_EN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module hazard_control_unit #(
   parameter int NB_REG_ADDR  = 5,
   parameter int DRAIN_CYCLES = 4,
   parameter int NB_CNT       = 32
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_valid,
   input  logic [NB_REG_ADDR-1:0] i_rs,
   input  logic [NB_REG_ADDR-1:0] i_rt,
   input  logic                   i_uses_rt,
   input  logic                   i_branch,
   input  logic                   i_jump_rs,
   input  logic                   i_taken,
   input  logic                   i_halt,
   input  logic [NB_REG_ADDR-1:0] i_rd_ex,
   input  logic                   i_we_ex,
   input  logic                   i_memread_ex,
   input  logic [NB_REG_ADDR-1:0] i_rd_mem,
   input  logic                   i_we_mem,
   input  logic                   i_memread_mem,
   output logic                   o_stall,
   output logic                   o_bubble,
   output logic                   o_flush,
   output logic                   o_halted,
   output logic [NB_CNT-1:0]      o_stall_cnt
);

   localparam int NB_DRAIN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [NB_DRAIN-1:0] C_DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [NB_DRAIN-1:0] r_drain_cnt;
   logic [NB_DRAIN-1:0] w_drain_cnt_next;

   logic w_hit_ex_a;
   logic w_hit_ex_b;
   logic w_hit_mem_a;
   logic w_hit_mem_b;
   logic w_load_use;
   logic w_br_hz;
   logic w_jr_hz;
   logic w_hazard;

   // Register 0 is hardwired, so a write to it never creates a dependency.
   assign w_hit_ex_a  = (i_rs == i_rd_ex) & i_we_ex & (i_rd_ex != '0);
   assign w_hit_ex_b  = i_uses_rt & (i_rt == i_rd_ex) & i_we_ex & (i_rd_ex != '0);
   assign w_hit_mem_a = (i_rs == i_rd_mem) & i_we_mem & (i_rd_mem != '0);
   assign w_hit_mem_b = i_uses_rt & (i_rt == i_rd_mem) & i_we_mem & (i_rd_mem != '0);

   assign w_load_use = i_memread_ex & (w_hit_ex_a | w_hit_ex_b);
   assign w_br_hz    = i_branch & (w_hit_ex_a | w_hit_ex_b
                                   | (i_memread_mem & (w_hit_mem_a | w_hit_mem_b)));
   assign w_jr_hz    = i_jump_rs & (w_hit_ex_a | (i_memread_mem & w_hit_mem_a));
   assign w_hazard   = w_load_use | w_br_hz | w_jr_hz;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state     <= RUN;
         r_drain_cnt <= '0;
      end else if (i_valid) begin
         r_state     <= w_state_next;
         r_drain_cnt <= w_drain_cnt_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_drain_cnt_next = r_drain_cnt;
      o_stall          = 1'b0;
      o_bubble         = 1'b0;
      o_flush          = 1'b0;
      o_halted         = 1'b0;
      if (!i_reset) begin
         case (r_state)
            RUN: begin
               // A stalled ID instruction is re-presented, so its taken/halt
               // status is acted upon only once the hazard clears.
               if (w_hazard) begin
                  o_stall  = 1'b1;
                  o_bubble = 1'b1;
               end else if (i_halt) begin
                  o_stall          = 1'b1;
                  o_bubble         = 1'b1;
                  w_state_next     = DRAIN;
                  w_drain_cnt_next = C_DRAIN_LOAD;
               end else if (i_taken) begin
                  o_flush = 1'b1;
               end
            end
            DRAIN: begin
               o_stall  = 1'b1;
               o_bubble = 1'b1;
               o_flush  = 1'b1;
               if (r_drain_cnt == '0) begin
                  w_state_next = HALTED;
               end else begin
                  w_drain_cnt_next = r_drain_cnt - 1'b1;
               end
            end
            HALTED: begin
               o_stall  = 1'b1;
               o_bubble = 1'b1;
               o_halted = 1'b1;
            end
            default: begin
               w_state_next = RUN;
            end
         endcase
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   logic [NB_CNT-1:0] r_stall_cnt;

   // Counts hazard stalls only; halt-related stall cycles are excluded.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_stall_cnt <= '0;
      end else if (i_valid && (r_state == RUN) && w_hazard && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign o_stall_cnt = r_stall_cnt;
`else
   assign o_stall_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
// =============================================================================
// Module   : tb_hazard_control_unit
// Brief    : Scoreboard bench for hazard_control_unit (RUN/DRAIN/HALTED paths).
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_hazard_control_unit;

   localparam int NB_REG_ADDR  = 5;
   localparam int DRAIN_CYCLES = 4;
   localparam int NB_CNT       = 32;

   logic                   i_clock = 1'b0;
   logic                   i_reset;
   logic                   i_valid;
   logic [NB_REG_ADDR-1:0] i_rs, i_rt, i_rd_ex, i_rd_mem;
   logic                   i_uses_rt, i_branch, i_jump_rs, i_taken, i_halt;
   logic                   i_we_ex, i_memread_ex, i_we_mem, i_memread_mem;
   logic                   o_stall, o_bubble, o_flush, o_halted;
   logic [NB_CNT-1:0]      o_stall_cnt;

   typedef struct {
      string       tag;
      logic        stall;
      logic        bubble;
      logic        flush;
      logic        halted;
      logic [31:0] cnt;
   } exp_t;

   exp_t q_exp[$];
   int   n_checks = 0;
   int   n_errors = 0;

   hazard_control_unit #(
      .NB_REG_ADDR (NB_REG_ADDR),
      .DRAIN_CYCLES(DRAIN_CYCLES),
      .NB_CNT      (NB_CNT)
   ) u_dut (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_valid      (i_valid),
      .i_rs         (i_rs),
      .i_rt         (i_rt),
      .i_uses_rt    (i_uses_rt),
      .i_branch     (i_branch),
      .i_jump_rs    (i_jump_rs),
      .i_taken      (i_taken),
      .i_halt       (i_halt),
      .i_rd_ex      (i_rd_ex),
      .i_we_ex      (i_we_ex),
      .i_memread_ex (i_memread_ex),
      .i_rd_mem     (i_rd_mem),
      .i_we_mem     (i_we_mem),
      .i_memread_mem(i_memread_mem),
      .o_stall      (o_stall),
      .o_bubble     (o_bubble),
      .o_flush      (o_flush),
      .o_halted     (o_halted),
      .o_stall_cnt  (o_stall_cnt)
   );

   always #5 i_clock = ~i_clock;

   function automatic int exp_cnt(input int n);
`ifdef HAZARD_STALL_CNT_EN
      return n;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_inputs();
      i_valid       = 1'b1;
      i_rs          = '0;
      i_rt          = '0;
      i_uses_rt     = 1'b0;
      i_branch      = 1'b0;
      i_jump_rs     = 1'b0;
      i_taken       = 1'b0;
      i_halt        = 1'b0;
      i_rd_ex       = '0;
      i_we_ex       = 1'b0;
      i_memread_ex  = 1'b0;
      i_rd_mem      = '0;
      i_we_mem      = 1'b0;
      i_memread_mem = 1'b0;
   endtask

   // Inputs are already applied (posedge+1); push expectation, sample mid-cycle,
   // then move on to just after the next edge.
   task automatic step(input string tag, input logic es, input logic eb,
                       input logic ef, input logic eh, input int ec);
      exp_t e;
      exp_t s;
      e.tag = tag; e.stall = es; e.bubble = eb; e.flush = ef; e.halted = eh;
      e.cnt = 32'(ec);
      q_exp.push_back(e);
      #4;
      s = q_exp.pop_front();
      check({s.tag, ".stall"},  64'(o_stall),     64'(s.stall));
      check({s.tag, ".bubble"}, 64'(o_bubble),    64'(s.bubble));
      check({s.tag, ".flush"},  64'(o_flush),     64'(s.flush));
      check({s.tag, ".halted"}, 64'(o_halted),    64'(s.halted));
      check({s.tag, ".cnt"},    64'(o_stall_cnt), 64'(s.cnt));
      @(posedge i_clock);
      #1;
   endtask

   initial begin
      clear_inputs();
      i_reset = 1'b1;
      repeat (2) @(posedge i_clock);
      #1;

      // Reset forces outputs low even with a halt and a load-use pending
      i_halt = 1'b1; i_rd_ex = 5'd8; i_we_ex = 1'b1; i_memread_ex = 1'b1; i_rs = 5'd8;
      step("reset", 0, 0, 0, 0, 0);
      clear_inputs();
      i_reset = 1'b0;
      step("idle", 0, 0, 0, 0, 0);

      // Load-use: single stall cycle
      i_rd_ex = 5'd8; i_we_ex = 1'b1; i_memread_ex = 1'b1; i_rs = 5'd8;
      step("lu1", 1, 1, 0, 0, exp_cnt(0));
      clear_inputs();
      i_rs = 5'd8; i_rd_mem = 5'd8; i_we_mem = 1'b1; i_memread_mem = 1'b1;
      step("lu2", 0, 0, 0, 0, exp_cnt(1));

      // Load feeding beq: EX match then MEM-load match
      clear_inputs();
      i_branch = 1'b1; i_rs = 5'd3; i_rd_ex = 5'd3; i_we_ex = 1'b1; i_memread_ex = 1'b1;
      step("lb1", 1, 1, 0, 0, exp_cnt(1));
      clear_inputs();
      i_branch = 1'b1; i_rs = 5'd3; i_rd_mem = 5'd3; i_we_mem = 1'b1; i_memread_mem = 1'b1;
      step("lb2", 1, 1, 0, 0, exp_cnt(2));
      clear_inputs();
      i_branch = 1'b1; i_rs = 5'd3;
      step("lb3", 0, 0, 0, 0, exp_cnt(3));

      // Register zero never matches
      clear_inputs();
      i_rd_ex = 5'd0; i_we_ex = 1'b1; i_memread_ex = 1'b1; i_uses_rt = 1'b1;
      step("r0", 0, 0, 0, 0, exp_cnt(3));

      // Taken branch, no hazard
      clear_inputs();
      i_branch = 1'b1; i_rs = 5'd5; i_taken = 1'b1; i_rd_ex = 5'd6; i_we_ex = 1'b1;
      step("tk", 0, 0, 1, 0, exp_cnt(3));

      // Taken branch behind an ALU producer: flush waits for the hazard to clear
      clear_inputs();
      i_branch = 1'b1; i_rs = 5'd9; i_taken = 1'b1; i_rd_ex = 5'd9; i_we_ex = 1'b1;
      step("tkh1", 1, 1, 0, 0, exp_cnt(3));
      clear_inputs();
      i_branch = 1'b1; i_rs = 5'd9; i_taken = 1'b1; i_rd_mem = 5'd9; i_we_mem = 1'b1;
      step("tkh2", 0, 0, 1, 0, exp_cnt(4));

      // jr on a load in MEM
      clear_inputs();
      i_jump_rs = 1'b1; i_rs = 5'd10; i_rd_mem = 5'd10; i_we_mem = 1'b1; i_memread_mem = 1'b1;
      step("jr", 1, 1, 0, 0, exp_cnt(4));

      // rt matches only when the instruction reads rt
      clear_inputs();
      i_rs = 5'd1; i_rt = 5'd8; i_rd_ex = 5'd8; i_we_ex = 1'b1; i_memread_ex = 1'b1;
      step("rt0", 0, 0, 0, 0, exp_cnt(5));
      i_uses_rt = 1'b1;
      step("rt1", 1, 1, 0, 0, exp_cnt(5));

      // Invalid step: outputs still driven, counter holds
      i_valid = 1'b0;
      step("nv1", 1, 1, 0, 0, exp_cnt(6));
      clear_inputs();
      step("nv2", 0, 0, 0, 0, exp_cnt(6));

      // Halt wins over taken; then 4 valid drain cycles with a 2-cycle gap
      i_halt = 1'b1; i_taken = 1'b1;
      step("halt", 1, 1, 0, 0, exp_cnt(6));
      clear_inputs();
      step("dr1", 1, 1, 1, 0, exp_cnt(6));
      step("dr2", 1, 1, 1, 0, exp_cnt(6));
      i_valid = 1'b0;
      step("drg1", 1, 1, 1, 0, exp_cnt(6));
      step("drg2", 1, 1, 1, 0, exp_cnt(6));
      i_valid = 1'b1;
      step("dr3", 1, 1, 1, 0, exp_cnt(6));
      step("dr4", 1, 1, 1, 0, exp_cnt(6));
      for (int k = 0; k < 3; k++) begin
         i_taken = 1'b1; i_halt = 1'b1;
         i_rd_ex = 5'd8; i_we_ex = 1'b1; i_memread_ex = 1'b1; i_rs = 5'd8;
         step($sformatf("hlt%0d", k), 1, 1, 0, 1, exp_cnt(6));
      end

      // Reset out of HALTED
      clear_inputs();
      i_reset = 1'b1;
      step("rsth", 0, 0, 0, 0, exp_cnt(6));
      i_reset = 1'b0;
      step("run", 0, 0, 0, 0, 0);
      i_rd_ex = 5'd8; i_we_ex = 1'b1; i_memread_ex = 1'b1; i_rs = 5'd8;
      step("run_lu", 1, 1, 0, 0, 0);
      clear_inputs();
      step("run_cnt", 0, 0, 0, 0, exp_cnt(1));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
